// File: rtl/brain_pkt_pkg.sv
// Constants and types shared by the brainwave link transmitter and receiver.
// The receiver's ThinkGear parser uses the same framing constants.
package brain_pkt_pkg;

   localparam logic [7:0] SYNC_BYTE        = 8'hAA;
   localparam logic [7:0] PLEN             = 8'h06;
   localparam logic [7:0] CODE_POOR_SIGNAL = 8'h02;
   localparam logic [7:0] CODE_ATTENTION   = 8'h04;
   localparam logic [7:0] CODE_MEDITATION  = 8'h05;
   localparam int         FRAME_BYTES      = 10;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP
   } tx_state_t;

   // Byte idx of the frame AA AA 06 02 S 04 A 05 M CHK; chk_acc is the running payload sum.
   function automatic logic [7:0] frame_byte(input logic [3:0]  idx,
                                             input logic [23:0] word,
                                             input logic [7:0]  chk_acc);
      case (idx)
         4'd0, 4'd1: frame_byte = SYNC_BYTE;
         4'd2:       frame_byte = PLEN;
         4'd3:       frame_byte = CODE_POOR_SIGNAL;
         4'd4:       frame_byte = word[23:16];
         4'd5:       frame_byte = CODE_ATTENTION;
         4'd6:       frame_byte = word[15:8];
         4'd7:       frame_byte = CODE_MEDITATION;
         4'd8:       frame_byte = word[7:0];
         default:    frame_byte = ~chk_acc;
      endcase
   endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// UART 8N1 byte serializer with a registered line output. A new byte can be
// taken in the last cycle of a stop bit, so consecutive bytes have no gap.
module uart_tx_byte
   import brain_pkt_pkg::*;
#(
   parameter int CLKS_PER_BIT = 1736
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tx_valid,
   input  logic [7:0] tx_data,
   output logic       tx_ready,
   output logic       rs232_tx
);

   localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   tx_state_t        state;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       bit_idx;
   logic [7:0]       shreg;
   logic             bit_end;

   assign bit_end  = (cnt == CNT_LAST);
   assign tx_ready = (state == ST_IDLE) || (state == ST_STOP && bit_end);

   // NOTE: state registers use non-blocking assignments so every register
   // samples the values from before the edge, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         bit_idx  <= '0;
         shreg    <= '0;
         rs232_tx <= 1'b1;
      end else begin
         cnt <= (state == ST_IDLE || bit_end) ? '0 : cnt + CNT_W'(1);
         case (state)
            ST_IDLE: begin
               if (tx_valid) begin
                  state    <= ST_START;
                  rs232_tx <= 1'b0;
                  shreg    <= tx_data;
               end
            end
            ST_START: begin
               if (bit_end) begin
                  state    <= ST_DATA;
                  bit_idx  <= '0;
                  rs232_tx <= shreg[0];
                  shreg    <= {1'b0, shreg[7:1]};
               end
            end
            ST_DATA: begin
               if (bit_end) begin
                  if (bit_idx == 3'd7) begin
                     state    <= ST_STOP;
                     rs232_tx <= 1'b1;
                  end else begin
                     bit_idx  <= bit_idx + 3'd1;
                     rs232_tx <= shreg[0];
                     shreg    <= {1'b0, shreg[7:1]};
                  end
               end
            end
            ST_STOP: begin
               // Chain straight into the next start bit when a byte is waiting.
               if (bit_end) begin
                  if (tx_valid) begin
                     state    <= ST_START;
                     rs232_tx <= 1'b0;
                     shreg    <= tx_data;
                  end else begin
                     state <= ST_IDLE;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/brain_pkt_tx.sv
// Brainwave link transmitter: snapshots signal/attention/meditation on send and
// emits one 10-byte ThinkGear packet over UART 8N1.
module brain_pkt_tx
   import brain_pkt_pkg::*;
#(
   parameter int CLKS_PER_BIT = 1736
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        send,
   input  logic [23:0] data_in,
   output logic        busy,
   output logic        done,
   output logic        rs232_tx
);

   localparam logic [3:0] LAST_IDX = 4'(FRAME_BYTES - 1);

   logic [23:0] word;
   logic [3:0]  byte_idx;
   logic [7:0]  chk;
   logic        accept;
   logic        byte_end;
   logic        next_byte;
   logic        last_end;
   logic        tx_valid;
   logic        tx_ready;
   logic [3:0]  load_idx;
   logic [7:0]  tx_data;

   // While busy the serializer is never idle, so tx_ready marks a stop-bit end.
   assign accept    = send && !busy;
   assign byte_end  = busy && tx_ready;
   assign next_byte = byte_end && (byte_idx != LAST_IDX);
   assign last_end  = byte_end && (byte_idx == LAST_IDX);
   assign tx_valid  = accept || next_byte;
   assign load_idx  = accept ? 4'd0 : byte_idx + 4'd1;

   // NOTE: a combinational block assigns its output on every path (here via a
   // single unconditional assignment) so no latch is inferred.
   always_comb begin
      tx_data = frame_byte(load_idx, word, chk);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy     <= 1'b0;
         done     <= 1'b0;
         word     <= '0;
         byte_idx <= '0;
         chk      <= '0;
      end else begin
         done <= 1'b0;
         if (accept) begin
            busy     <= 1'b1;
            word     <= data_in;
            byte_idx <= '0;
            chk      <= '0;
         end else if (next_byte) begin
            byte_idx <= load_idx;
            // Payload bytes 02 S 04 A 05 M sit at indices 3..8.
            if (load_idx >= 4'd3 && load_idx < LAST_IDX)
               chk <= chk + tx_data;
         end else if (last_end) begin
            busy     <= 1'b0;
            done     <= 1'b1;
            byte_idx <= '0;
         end
      end
   end

   uart_tx_byte #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_uart_tx_byte (
      .clk      (clk),
      .rst      (rst),
      .tx_valid (tx_valid),
      .tx_data  (tx_data),
      .tx_ready (tx_ready),
      .rs232_tx (rs232_tx)
   );

endmodule

// File: tb/tb_brain_pkt_tx.sv
// Bench for brain_pkt_tx: decodes the serial line at mid-bit and compares frames,
// busy/done timing and reset behaviour against a packet model.
module tb_brain_pkt_tx;

   localparam int CPB = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        send = 1'b0;
   logic [23:0] data_in = '0;
   logic        busy;
   logic        done;
   logic        rs232_tx;

   int vectors = 0;
   int errors  = 0;
   int busy_cnt = 0;
   int done_cnt = 0;
   int busy_base;

   brain_pkt_tx #(
      .CLKS_PER_BIT(CPB)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .send     (send),
      .data_in  (data_in),
      .busy     (busy),
      .done     (done),
      .rs232_tx (rs232_tx)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (busy) busy_cnt <= busy_cnt + 1;
      if (done) done_cnt <= done_cnt + 1;
   end

   // Packet model: sync, length, three code/value pairs, then 255 - (sum mod 256).
   task automatic model_frame(input logic [23:0] w, output logic [7:0] f [10]);
      int s;
      f[0] = 8'hAA; f[1] = 8'hAA; f[2] = 8'h06;
      f[3] = 8'h02; f[4] = w[23:16];
      f[5] = 8'h04; f[6] = w[15:8];
      f[7] = 8'h05; f[8] = w[7:0];
      s = 2 + 4 + 5 + int'(w[23:16]) + int'(w[15:8]) + int'(w[7:0]);
      f[9] = 8'(255 - (s % 256));
   endtask

   // Issue a one-cycle send; returns at the negedge after the accepting edge.
   task automatic start_frame(input logic [23:0] w);
      @(negedge clk);
      data_in   = w;
      send      = 1'b1;
      busy_base = busy_cnt;
      @(posedge clk);
      @(negedge clk);
      send = 1'b0;
   endtask

   // Sample all 100 bit times at mid-bit relative to the accepting edge.
   task automatic rx_frame(output logic [7:0] got [10], output int ferr);
      int cur = 0;
      int tgt;
      ferr = 0;
      for (int k = 0; k < 10; k++) begin
         for (int b = 0; b < 10; b++) begin
            tgt = (k * 10 + b) * CPB + CPB / 2;
            repeat (tgt - cur) @(negedge clk);
            cur = tgt;
            if (b == 0)      ferr += (rs232_tx !== 1'b0) ? 1 : 0;
            else if (b == 9) ferr += (rs232_tx !== 1'b1) ? 1 : 0;
            else             got[k][b-1] = rs232_tx;
         end
      end
   endtask

   task automatic compare_frame(input string name, input logic [23:0] w,
                                input logic [7:0] got [10], input int ferr);
      logic [7:0] exp_f [10];
      model_frame(w, exp_f);
      for (int k = 0; k < 10; k++) begin
         vectors++;
         if (got[k] !== exp_f[k]) begin
            errors++;
            $display("FAIL %s byte%0d: got %h want %h", name, k, got[k], exp_f[k]);
         end
      end
      vectors++;
      if (ferr !== 0) begin
         errors++;
         $display("FAIL %s framing: got %0d bad start/stop bits want 0", name, ferr);
      end
   endtask

   // From the last mid-bit sample, step to the final stop-bit edge and check busy/done.
   task automatic check_end(input string name);
      repeat (CPB / 2 - 1) @(negedge clk);
      vectors++;
      if (busy !== 1'b1 || done !== 1'b0) begin
         errors++;
         $display("FAIL %s pre_end: got busy=%b done=%b want busy=1 done=0", name, busy, done);
      end
      @(negedge clk);
      vectors++;
      if (busy !== 1'b0 || done !== 1'b1 || rs232_tx !== 1'b1) begin
         errors++;
         $display("FAIL %s end: got busy=%b done=%b tx=%b want 0 1 1", name, busy, done, rs232_tx);
      end
   endtask

   task automatic test_frame(input string name, input logic [23:0] w);
      logic [7:0] got [10];
      int ferr;
      int dbase;
      dbase = done_cnt;
      start_frame(w);
      rx_frame(got, ferr);
      compare_frame(name, w, got, ferr);
      check_end(name);
      vectors++;
      if (busy_cnt - busy_base !== 100 * CPB) begin
         errors++;
         $display("FAIL %s busy_len: got %0d want %0d", name, busy_cnt - busy_base, 100 * CPB);
      end
      @(negedge clk);
      vectors++;
      if (done !== 1'b0 || done_cnt - dbase !== 1) begin
         errors++;
         $display("FAIL %s done_pulse: got done=%b pulses=%0d want 0 1", name, done, done_cnt - dbase);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      vectors++;
      if (rs232_tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL reset_hold: got tx=%b busy=%b done=%b want 1 0 0", rs232_tx, busy, done);
      end
      rst = 1'b0;
      repeat (3) @(negedge clk);
      vectors++;
      if (rs232_tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle: got tx=%b busy=%b done=%b want 1 0 0", rs232_tx, busy, done);
      end
   endtask

   task automatic test_checksum();
      test_frame("basic", 24'h003241);
      test_frame("chk_2c", 24'hC80000);
      test_frame("chk_wrap", 24'hFFFFFF);
   endtask

   task automatic test_random();
      for (int i = 0; i < 4; i++)
         test_frame($sformatf("rand%0d", i), 24'($urandom));
   endtask

   task automatic test_ignore();
      logic [7:0]  got [10];
      int          ferr;
      int          dbase;
      int          bbase;
      logic [23:0] w;
      w     = 24'($urandom);
      dbase = done_cnt;
      start_frame(w);
      fork
         rx_frame(got, ferr);
         begin
            repeat (50) @(negedge clk);
            data_in = 24'h123456;
            send    = 1'b1;
            @(negedge clk);
            send = 1'b0;
            repeat (349) @(negedge clk);
            send = 1'b1;
            @(negedge clk);
            send = 1'b0;
         end
      join
      compare_frame("ignore", w, got, ferr);
      check_end("ignore");
      bbase = busy_cnt;
      repeat (20) @(negedge clk);
      vectors++;
      if (done_cnt - dbase !== 1 || busy_cnt - bbase !== 0) begin
         errors++;
         $display("FAIL ignore_single: got pulses=%0d busy_after=%0d want 1 0",
                  done_cnt - dbase, busy_cnt - bbase);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0]  got [10];
      int          ferr;
      logic [23:0] w1;
      logic [23:0] w2;
      w1 = 24'($urandom);
      w2 = 24'($urandom);
      @(negedge clk);
      data_in = w1;
      send    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rx_frame(got, ferr);
      compare_frame("b2b_f1", w1, got, ferr);
      check_end("b2b_f1");
      data_in = w2;
      @(negedge clk);
      vectors++;
      if (rs232_tx !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL b2b_restart: got tx=%b busy=%b want 0 1", rs232_tx, busy);
      end
      send = 1'b0;
      rx_frame(got, ferr);
      compare_frame("b2b_f2", w2, got, ferr);
      check_end("b2b_f2");
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      logic [7:0]  exp_f [10];
      logic [23:0] w;
      int          dbase;
      int          low_cycles;
      w = 24'($urandom);
      model_frame(w, exp_f);
      start_frame(w);
      repeat (300) @(negedge clk);
      // Cycle 300 is bit 37: byte 3, data bit 6.
      vectors++;
      if (rs232_tx !== exp_f[3][6] || busy !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_pre: got tx=%b busy=%b want %b 1", rs232_tx, busy, exp_f[3][6]);
      end
      dbase = done_cnt;
      rst = 1'b1;
      #1;
      vectors++;
      if (rs232_tx !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_async: got tx=%b busy=%b want 1 0", rs232_tx, busy);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      low_cycles = 0;
      repeat (900) begin
         @(negedge clk);
         if (rs232_tx !== 1'b1) low_cycles++;
      end
      vectors++;
      if (done_cnt - dbase !== 0 || low_cycles !== 0) begin
         errors++;
         $display("FAIL rstmid_quiet: got pulses=%0d low=%0d want 0 0", done_cnt - dbase, low_cycles);
      end
      test_frame("post_rst", 24'($urandom));
   endtask

   initial begin
      test_reset();
      test_checksum();
      test_random();
      test_ignore();
      test_back_to_back();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
